// File: rtl/gray_codec_pipe.sv
// Multi-channel gray<->binary converter pipeline with valid/ready flow control.
// Gray-to-binary resolves its XOR prefix chain a slice of bits per stage; binary outputs are step-checked.
module gray_codec_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1,
  parameter int STAGES   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_mode,
  output logic [WIDTH*CHANNELS-1:0] out_data,
  output logic [CHANNELS-1:0]       out_step_err
);
  localparam int DW  = WIDTH * CHANNELS;
  localparam int BPS = (WIDTH + STAGES - 1) / STAGES;

  logic [DW-1:0]       data_q [STAGES];
  logic [DW-1:0]       data_d [STAGES];
  logic [STAGES-1:0]   mode_q, mode_d;
  logic [STAGES-1:0]   vld_q, vld_d;
  logic                advance;

  logic [WIDTH-1:0]    prev_bin_q [CHANNELS];
  logic [WIDTH-1:0]    prev_bin_d [CHANNELS];
  logic [CHANNELS-1:0] prev_vld_q, prev_vld_d;
  logic                take_bin;

  function automatic logic [DW-1:0] bin_to_gray(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = w;
    for (int c = 0; c < CHANNELS; c++)
      r[c*WIDTH +: WIDTH] = w[c*WIDTH +: WIDTH] ^ (w[c*WIDTH +: WIDTH] >> 1);
    return r;
  endfunction

  // Bits above this stage's slice are already binary, so each slice bit folds in its upper neighbour.
  function automatic logic [DW-1:0] gray_slice(input logic [DW-1:0] w, input int stage);
    logic [DW-1:0] r;
    int            hi;
    int            lo;
    r  = w;
    hi = WIDTH - 1 - stage * BPS;
    lo = hi - BPS + 1;
    for (int c = 0; c < CHANNELS; c++)
      for (int i = WIDTH - 2; i >= 0; i--)
        if (i >= lo && i <= hi)
          r[c*WIDTH + i] = r[c*WIDTH + i] ^ r[c*WIDTH + i + 1];
    return r;
  endfunction

  function automatic logic step_bad(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] prev);
    logic [WIDTH-1:0] nxt;
    nxt = prev + 1'b1;
    return (cur != prev) && (cur != nxt);
  endfunction

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    for (int s = 0; s < STAGES; s++)
      data_d[s] = data_q[s];
    if (advance) begin
      vld_d[0]  = in_valid && in_ready;
      mode_d[0] = in_mode;
      data_d[0] = in_mode ? bin_to_gray(in_data) : gray_slice(in_data, 0);
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s]  = vld_q[s-1];
        mode_d[s] = mode_q[s-1];
        data_d[s] = mode_q[s-1] ? data_q[s-1] : gray_slice(data_q[s-1], s);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++)
      data_q[s] <= data_d[s];
    mode_q <= mode_d;
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // ---- output stage: gated by rst so nothing is presented during the reset cycle itself
  assign out_valid = vld_q[STAGES-1] && !rst;
  assign out_mode  = mode_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign take_bin  = out_valid && out_ready && !out_mode;

  always_comb begin
    out_step_err = '0;
    prev_vld_d   = prev_vld_q;
    for (int c = 0; c < CHANNELS; c++) begin
      prev_bin_d[c] = prev_bin_q[c];
      if (out_valid && !out_mode && prev_vld_q[c] &&
          step_bad(out_data[c*WIDTH +: WIDTH], prev_bin_q[c]))
        out_step_err[c] = 1'b1;
      if (take_bin) begin
        prev_bin_d[c] = out_data[c*WIDTH +: WIDTH];
        prev_vld_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++)
      prev_bin_q[c] <= prev_bin_d[c];
    if (rst) prev_vld_q <= '0;
    else     prev_vld_q <= prev_vld_d;
  end

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: a 4-bit single-stage instance for the worked examples and an
// 8-bit two-channel three-stage instance for flow control, sweeps and mid-flight reset.
`timescale 1ns/1ps
module tb_gray_codec_pipe;
  typedef struct {
    logic        mode;
    logic [15:0] data;
    logic [1:0]  err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
  logic [3:0] a_in_data, a_out_data;
  logic [0:0] a_out_step_err;

  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_out_step_err;

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] pb [2];
  logic       pv [2];

  gray_codec_pipe #(.WIDTH(4), .CHANNELS(1), .STAGES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mode(a_out_mode),
    .out_data(a_out_data), .out_step_err(a_out_step_err));

  gray_codec_pipe #(.WIDTH(8), .CHANNELS(2), .STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode),
    .out_data(b_out_data), .out_step_err(b_out_step_err));

  function automatic logic [31:0] g2b(input logic [31:0] g, input int w);
    logic [31:0] b;
    b = 32'd0;
    for (int i = 0; i < w; i++) b = b ^ (g >> i);
    return b & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] b2g(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t model_b(input logic mode, input logic [15:0] d);
    exp_t       e;
    logic [7:0] w;
    logic [7:0] o;
    e.mode = mode; e.err = 2'b00; e.data = 16'h0;
    for (int c = 0; c < 2; c++) begin
      w = d[c*8 +: 8];
      if (mode) o = 8'(b2g({24'd0, w}));
      else begin
        o = 8'(g2b({24'd0, w}, 8));
        if (pv[c] && o != pb[c] && o != 8'(pb[c] + 8'd1)) e.err[c] = 1'b1;
        pv[c] = 1'b1;
        pb[c] = o;
      end
      e.data[c*8 +: 8] = o;
    end
    return e;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    qa.delete(); qb.delete();
    pv[0] = 1'b0; pv[1] = 1'b0;
  endtask

  task automatic a_beat(input logic m, input logic [3:0] d, input logic [3:0] o, input logic e);
    exp_t x;
    x.mode = m; x.data = {12'd0, o}; x.err = {1'b0, e};
    qa.push_back(x);
    a_in_valid = 1'b1; a_in_mode = m; a_in_data = d;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_in_mode = 1'b0; a_in_data = 4'h0; b_in_mode = 1'b0; b_in_data = 16'h0;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    rst = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
    qa.delete(); qb.delete(); pv[0] = 1'b0; pv[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_a_out_valid got=%b want=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_a_in_ready got=%b want=1", a_in_ready); end
    checks++; if (a_out_step_err !== 1'b0) begin failures++; $display("FAIL reset_a_err got=%b want=0", a_out_step_err); end
    checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_b_out_valid got=%b want=0", b_out_valid); end
    checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_in_ready got=%b want=1", b_in_ready); end
    checks++; if (b_out_step_err !== 2'b00) begin failures++; $display("FAIL reset_b_err got=%b want=00", b_out_step_err); end
    @(posedge clk);
    #1 rst = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got=%b%b want=00", a_out_valid, b_out_valid); end
  endtask

  task automatic test_convert();
    logic       m [2] = '{1'b0, 1'b1};
    logic [3:0] d [2] = '{4'b1101, 4'b1001};
    logic [3:0] o [2] = '{4'b1001, 4'b1101};
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      a_beat(m[i], d[i], o[i], 1'b0);
      x = qa.pop_front();
      checks++; if (a_out_valid !== 1'b1 || a_out_mode !== x.mode || a_out_data !== x.data[3:0]) begin
        failures++; $display("FAIL convert_%0d got v=%b m=%b d=%b want v=1 m=%b d=%b", i,
                             a_out_valid, a_out_mode, a_out_data, x.mode, x.data[3:0]); end
      checks++; if (a_out_step_err !== x.err[0:0]) begin
        failures++; $display("FAIL convert_err_%0d got=%b want=%b", i, a_out_step_err, x.err[0]); end
    end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL convert_no_dup got=%b want=0", a_out_valid); end
  endtask

  task automatic test_step();
    logic [3:0] g  [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b0011, 4'b0011};
    logic       e  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       rs [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t x;
    for (int i = 0; i < 6; i++) begin
      if (rs[i]) do_reset(1);
      a_beat(1'b0, g[i], 4'(g2b({28'd0, g[i]}, 4)), e[i]);
      x = qa.pop_front();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== x.data[3:0] || a_out_step_err !== x.err[0:0]) begin
        failures++; $display("FAIL step_%0d got v=%b d=%b e=%b want v=1 d=%b e=%b", i,
                             a_out_valid, a_out_data, a_out_step_err, x.data[3:0], x.err[0]); end
    end
  endtask

  task automatic test_wrap();
    logic       m [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] d [5] = '{4'b1000, 4'b0000, 4'b0101, 4'b0001, 4'b0110};
    logic       e [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] o;
    exp_t x;
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      o = m[i] ? 4'(b2g({28'd0, d[i]})) : 4'(g2b({28'd0, d[i]}, 4));
      a_beat(m[i], d[i], o, e[i]);
      x = qa.pop_front();
      checks++; if (a_out_valid !== 1'b1 || a_out_mode !== x.mode || a_out_data !== x.data[3:0] ||
                    a_out_step_err !== x.err[0:0]) begin
        failures++; $display("FAIL wrap_%0d got m=%b d=%b e=%b want m=%b d=%b e=%b", i, a_out_mode,
                             a_out_data, a_out_step_err, x.mode, x.data[3:0], x.err[0]); end
    end
  endtask

  task automatic test_backpressure();
    exp_t x;
    int   sent = 0, got = 0, stall = 0, cyc = 0, first_in = -1, first_out = -1;
    logic stalled_once = 1'b0;
    do_reset(1);
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_mode = 1'b0;
    b_in_data = {8'(b2g(32'd200)), 8'(b2g(32'd0))};
    while ((sent < 20 || qb.size() > 0) && cyc < 300) begin
      @(negedge clk); cyc++;
      if (b_out_valid && first_out < 0) first_out = cyc;
      if (!b_out_ready && qb.size() > 0) begin
        checks++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1 || b_out_data !== qb[0].data ||
                      b_out_mode !== qb[0].mode) begin
          failures++; $display("FAIL bp_stall_hold got r=%b v=%b d=%h want r=0 v=1 d=%h", b_in_ready,
                               b_out_valid, b_out_data, qb[0].data); end
      end
      if (b_out_valid && b_out_ready) begin
        got++;
        if (qb.size() == 0) begin
          checks++; failures++; $display("FAIL bp_extra_beat got=%h want=none", b_out_data);
        end else begin
          x = qb.pop_front();
          checks++; if (b_out_data !== x.data || b_out_mode !== x.mode || b_out_step_err !== x.err) begin
            failures++; $display("FAIL bp_beat got d=%h m=%b e=%b want d=%h m=%b e=%b", b_out_data,
                                 b_out_mode, b_out_step_err, x.data, x.mode, x.err); end
        end
      end
      if (b_in_valid && b_in_ready) begin
        if (first_in < 0) first_in = cyc;
        qb.push_back(model_b(b_in_mode, b_in_data));
        sent++;
      end
      @(posedge clk); #1;
      b_in_valid = (sent < 20);
      b_in_mode  = (sent % 3 == 2);
      b_in_data  = {8'(b2g(32'(200 + sent))), 8'(b2g(32'(sent)))};
      if (b_out_valid && !stalled_once) begin
        b_out_ready = 1'b0; stall = 5; stalled_once = 1'b1;
      end else if (stall > 0) begin
        stall--;
        if (stall == 0) b_out_ready = 1'b1;
      end
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    checks++; if (first_out - first_in !== 3) begin
      failures++; $display("FAIL bp_latency got=%0d want=3", first_out - first_in); end
    checks++; if (got !== 20 || qb.size() !== 0) begin
      failures++; $display("FAIL bp_count got=%0d left=%0d want=20 left=0", got, qb.size()); end
  endtask

  task automatic test_sweep();
    exp_t st[$];
    exp_t x;
    int   cyc = 0, err0 = 0, err1 = 0;
    do_reset(1);
    for (int k = 0; k < 256; k++) begin
      if (k == 50 || k == 100 || k == 200) begin
        x.mode = 1'b0; x.err = 2'b00;
        x.data = {8'(b2g(32'((k + 127) % 256))), 8'(b2g(32'((k + 4) % 256)))};
        st.push_back(x);
      end
      x.mode = 1'b0; x.err = 2'b00;
      x.data = {8'(b2g(32'((k + 128) % 256))), 8'(b2g(32'(k)))};
      st.push_back(x);
    end
    for (int k = 0; k < 256; k++) begin
      x.mode = 1'b1; x.err = 2'b00; x.data = {8'(255 - k), 8'(k)};
      st.push_back(x);
    end
    while ((st.size() > 0 || qb.size() > 0) && cyc < 6000) begin
      @(posedge clk); #1;
      b_in_valid = (st.size() > 0) && ($urandom_range(0, 3) != 0);
      if (st.size() > 0) begin b_in_mode = st[0].mode; b_in_data = st[0].data; end
      b_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk); cyc++;
      if (!b_out_valid && b_out_step_err !== 2'b00) begin
        checks++; failures++; $display("FAIL sweep_idle_err got=%b want=00", b_out_step_err); end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          checks++; failures++; $display("FAIL sweep_extra_beat got=%h want=none", b_out_data);
        end else begin
          x = qb.pop_front();
          err0 += int'(b_out_step_err[0] === 1'b1);
          err1 += int'(b_out_step_err[1] === 1'b1);
          checks++; if (b_out_data !== x.data || b_out_mode !== x.mode || b_out_step_err !== x.err) begin
            failures++; $display("FAIL sweep_beat got d=%h m=%b e=%b want d=%h m=%b e=%b", b_out_data,
                                 b_out_mode, b_out_step_err, x.data, x.mode, x.err); end
        end
      end
      if (b_in_valid && b_in_ready) begin
        qb.push_back(model_b(b_in_mode, b_in_data));
        x = st.pop_front();
      end
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    checks++; if (cyc >= 6000) begin failures++; $display("FAIL sweep_timeout got=%0d want<6000", cyc); end
    checks++; if (err0 !== 6 || err1 !== 0) begin
      failures++; $display("FAIL sweep_err_count got=%0d,%0d want=6,0", err0, err1); end
  endtask

  task automatic test_midreset();
    exp_t x;
    int   w;
    logic [15:0] vals [3] = '{16'h0000, 16'h0000, 16'h0000};
    do_reset(1);
    b_out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      case (n)
        0: vals[0] = {8'(b2g(32'd10)), 8'(b2g(32'd0))};
        1: vals[0] = {8'(b2g(32'd99)), 8'(b2g(32'd200))};
        default: vals[0] = {8'(b2g(32'd100)), 8'(b2g(32'd7))};
      endcase
      if (n == 1) begin
        b_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = {8'(b2g(32'(i + 20))), 8'(b2g(32'(i + 1)))};
          @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        checks++; if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin
          failures++; $display("FAIL mid_full got v=%b r=%b want v=1 r=0", b_out_valid, b_in_ready); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", b_out_valid); end
        @(posedge clk); #1 rst = 1'b0;
        qb.delete(); pv[0] = 1'b0; pv[1] = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_%0d got=%b want=0", i, b_out_valid); end
        end
      end
      b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = vals[0];
      qb.push_back(model_b(1'b0, vals[0]));
      @(posedge clk); #1 b_in_valid = 1'b0;
      w = 0;
      @(negedge clk);
      while (!b_out_valid && w < 10) begin @(negedge clk); w++; end
      x = qb.pop_front();
      checks++; if (b_out_valid !== 1'b1 || b_out_data !== x.data || b_out_step_err !== x.err) begin
        failures++; $display("FAIL mid_beat_%0d got v=%b d=%h e=%b want v=1 d=%h e=%b", n, b_out_valid,
                             b_out_data, b_out_step_err, x.data, x.err); end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_step();
    test_wrap();
    test_backpressure();
    test_sweep();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
